// File: rtl/fofb_readout_sequencer_if.sv
// -----------------------------------------------------------------------------
// fofb_readout_sequencer_if
//
// Purpose: the beat stream from the FOFB readout sequencer to the correction
// datapath.
//
// Handshake: a beat transfers on every cycle where outValid and outReady are
// both high. The source never retracts a beat: while outValid is high and
// outReady is low, outValid stays high and outIndex/outLast/outX/outY/outS
// stay unchanged. outReady may be high while outValid is low.
//
// Signals:
//   outValid  source -> sink  beat valid
//   outReady  sink -> source  sink accepts the beat
//   outIndex  source -> sink  FOFB index of the beat
//   outX/Y/S  source -> sink  32-bit payload words
//   outLast   source -> sink  final beat of the scan
// -----------------------------------------------------------------------------
interface fofb_readout_sequencer_if #(
   parameter int FOFB_INDEX_WIDTH = 9
);
   logic                        outValid;
   logic                        outReady;
   logic [FOFB_INDEX_WIDTH-1:0] outIndex;
   logic [31:0]                 outX;
   logic [31:0]                 outY;
   logic [31:0]                 outS;
   logic                        outLast;

   modport master (
      output outValid,
      output outIndex,
      output outX,
      output outY,
      output outS,
      output outLast,
      input  outReady
   );

   modport slave (
      input  outValid,
      input  outIndex,
      input  outX,
      input  outY,
      input  outS,
      input  outLast,
      output outReady
   );
endinterface

// File: rtl/fofb_readout_sequencer.sv
// -----------------------------------------------------------------------------
// fofb_readout_sequencer
//
// Purpose: owns the read port of the FOFB link readout DPRAM (one-cycle read
// latency). On start it snapshots the present-BPM bitmap and walks the FOFB
// indices upward, reading only present BPMs, and streams {index, last, X, Y, S}
// beats to the correction datapath. A host read path shares the same DPRAM
// port through a round-robin arbiter.
//
// Ports:
//   sysClk, sysReset          clock, asynchronous active-high reset
//   start                     one-cycle pulse: begin a scan
//   bpmBitmap[N-1:0]          present-BPM map, sampled when start is accepted
//   readoutAddress            DPRAM read address
//   readoutX/Y/S              DPRAM data, valid one cycle after the address
//   out_bus (master)          beat stream, see fofb_readout_sequencer_if
//   hostReq, hostAddress      host read request (level) and index
//   hostValid, hostData       one-cycle pulse with {S,Y,X}
//   busy, done                scan in progress / one-cycle completion pulse
//   beatCount                 beats emitted by the last completed scan
//   overrunStrobe             start arrived while busy
//   dbg_state                 FSM state (0 idle, 1 scan, 2 drain)
// -----------------------------------------------------------------------------
module fofb_readout_sequencer #(
   parameter int FOFB_INDEX_WIDTH = 9
) (
   input  logic                             sysClk,
   input  logic                             sysReset,
   input  logic                             start,
   input  logic [(1<<FOFB_INDEX_WIDTH)-1:0] bpmBitmap,
   output logic [FOFB_INDEX_WIDTH-1:0]      readoutAddress,
   input  logic [31:0]                      readoutX,
   input  logic [31:0]                      readoutY,
   input  logic [31:0]                      readoutS,
   fofb_readout_sequencer_if.master         out_bus,
   input  logic                             hostReq,
   input  logic [FOFB_INDEX_WIDTH-1:0]      hostAddress,
   output logic                             hostValid,
   output logic [95:0]                      hostData,
   output logic                             busy,
   output logic                             done,
   output logic [FOFB_INDEX_WIDTH:0]        beatCount,
   output logic                             overrunStrobe,
   output logic [1:0]                       dbg_state
);

   localparam int W = FOFB_INDEX_WIDTH;
   localparam int N = 1 << W;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SCAN  = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;

   typedef struct packed {
      logic [W-1:0] idx;
      logic         last;
      logic [31:0]  s;
      logic [31:0]  y;
      logic [31:0]  x;
   } beat_t;

   // FSM and scanner state
   logic [1:0]   state_q, state_d;
   logic [N-1:0] snap_q, snap_d;
   logic [N-1:0] snap_next;
   logic [W-1:0] idx_q, idx_d;
   logic [W:0]   beat_cnt_q, beat_cnt_d;
   logic [W:0]   beat_count_q, beat_count_d;
   logic         done_c;

   // Reads in flight (issued last cycle, data on readoutX/Y/S this cycle)
   logic         scan_inflight_q, scan_inflight_d;
   logic [W-1:0] inflight_idx_q, inflight_idx_d;
   logic         inflight_last_q, inflight_last_d;
   logic         host_inflight_q, host_inflight_d;

   // Arbiter: 1 means the host wins the next contended cycle
   logic         prio_host_q, prio_host_d;

   // Two-entry output FIFO
   beat_t        fifo_q [2];
   beat_t        fifo_d [2];
   logic         wr_ptr_q, wr_ptr_d;
   logic         rd_ptr_q, rd_ptr_d;
   logic [1:0]   count_q, count_d;

   logic         head_valid;
   beat_t        head;
   beat_t        arriving;
   logic         pop;
   logic         pop_mem;
   logic         push;
   logic [1:0]   occ_after;
   logic         scan_req;
   logic         host_req;
   logic         grant_scan;
   logic         grant_host;

   // ---------------------------------------------------------------------------
   // Output buffer. A beat whose data is arriving this cycle is offered
   // directly when the FIFO is empty, so the first beat is visible two cycles
   // after start. If it is not taken it is written into the FIFO and presented
   // unchanged from there on the next cycle.
   // ---------------------------------------------------------------------------
   always_comb begin
      arriving.idx  = inflight_idx_q;
      arriving.last = inflight_last_q;
      arriving.s    = readoutS;
      arriving.y    = readoutY;
      arriving.x    = readoutX;
   end

   assign head_valid = (count_q != 2'd0) || scan_inflight_q;
   assign head       = (count_q != 2'd0) ? fifo_q[rd_ptr_q] : arriving;
   assign pop        = head_valid && out_bus.outReady;
   assign pop_mem    = pop && (count_q != 2'd0);
   assign push       = scan_inflight_q && !((count_q == 2'd0) && pop);

   always_comb begin
      fifo_d = fifo_q;
      if (push) begin
         fifo_d[wr_ptr_q] = arriving;
      end
      wr_ptr_d = wr_ptr_q ^ push;
      rd_ptr_d = rd_ptr_q ^ pop_mem;
      count_d  = count_q + {1'b0, push} - {1'b0, pop_mem};
   end

   // Entries that will still be held after this cycle's pop, counting the read
   // now in flight. Subtracting the pop lets a read issue every cycle while
   // the sink keeps up; keeping this below 2 bounds the FIFO at 2 entries.
   assign occ_after = count_q + {1'b0, scan_inflight_q} - {1'b0, pop};

   // ---------------------------------------------------------------------------
   // Arbitration: one DPRAM read per cycle. On contention the requester not
   // favoured last time wins; the preference only flips on contended cycles.
   // ---------------------------------------------------------------------------
   assign scan_req   = (state_q == ST_SCAN) && snap_q[0] && (occ_after < 2'd2);
   assign host_req   = hostReq && !host_inflight_q && !sysReset;
   assign grant_host = host_req && (!scan_req || prio_host_q);
   assign grant_scan = scan_req && (!host_req || !prio_host_q);

   always_comb begin
      readoutAddress = '0;
      if (grant_host) begin
         readoutAddress = hostAddress;
      end else if (grant_scan) begin
         readoutAddress = idx_q;
      end
   end

   always_comb begin
      scan_inflight_d = grant_scan;
      inflight_idx_d  = grant_scan ? idx_q : inflight_idx_q;
      // Last is known at issue: nothing is left above the current index.
      inflight_last_d = grant_scan ? (snap_q[N-1:1] == '0) : inflight_last_q;
      host_inflight_d = grant_host;
      prio_host_d     = (scan_req && host_req) ? !prio_host_q : prio_host_q;
   end

   // ---------------------------------------------------------------------------
   // Scan FSM. One index per cycle: absent BPMs are skipped, a present BPM
   // waits for its grant. The scan ends once the remaining snapshot is empty.
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d      = state_q;
      snap_d       = snap_q;
      idx_d        = idx_q;
      beat_cnt_d   = beat_cnt_q + (W+1)'(pop);
      beat_count_d = beat_count_q;
      done_c       = 1'b0;
      snap_next    = snap_q >> 1;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d    = ST_SCAN;
               snap_d     = bpmBitmap;
               idx_d      = '0;
               beat_cnt_d = '0;
            end
         end
         ST_SCAN: begin
            if (!snap_q[0] || grant_scan) begin
               snap_d = snap_next;
               idx_d  = idx_q + W'(1);
            end
            if (snap_d == '0) begin
               state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            // FIFO empty and nothing in flight also means no beat is handshaking.
            if ((count_q == 2'd0) && !scan_inflight_q) begin
               state_d      = ST_IDLE;
               done_c       = 1'b1;
               beat_count_d = beat_cnt_q;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge sysClk or posedge sysReset) begin
      if (sysReset) begin
         state_q         <= ST_IDLE;
         snap_q          <= '0;
         idx_q           <= '0;
         beat_cnt_q      <= '0;
         beat_count_q    <= '0;
         scan_inflight_q <= 1'b0;
         inflight_idx_q  <= '0;
         inflight_last_q <= 1'b0;
         host_inflight_q <= 1'b0;
         prio_host_q     <= 1'b0;
         fifo_q[0]       <= '0;
         fifo_q[1]       <= '0;
         wr_ptr_q        <= 1'b0;
         rd_ptr_q        <= 1'b0;
         count_q         <= 2'd0;
      end else begin
         state_q         <= state_d;
         snap_q          <= snap_d;
         idx_q           <= idx_d;
         beat_cnt_q      <= beat_cnt_d;
         beat_count_q    <= beat_count_d;
         scan_inflight_q <= scan_inflight_d;
         inflight_idx_q  <= inflight_idx_d;
         inflight_last_q <= inflight_last_d;
         host_inflight_q <= host_inflight_d;
         prio_host_q     <= prio_host_d;
         fifo_q          <= fifo_d;
         wr_ptr_q        <= wr_ptr_d;
         rd_ptr_q        <= rd_ptr_d;
         count_q         <= count_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs. Payload is forced to zero when no beat is offered so that every
   // output reads 0 while in reset.
   // ---------------------------------------------------------------------------
   assign out_bus.outValid = head_valid;
   assign out_bus.outIndex = head_valid ? head.idx  : '0;
   assign out_bus.outLast  = head_valid ? head.last : 1'b0;
   assign out_bus.outX     = head_valid ? head.x    : '0;
   assign out_bus.outY     = head_valid ? head.y    : '0;
   assign out_bus.outS     = head_valid ? head.s    : '0;

   assign hostValid     = host_inflight_q;
   assign hostData      = host_inflight_q ? {readoutS, readoutY, readoutX} : '0;
   assign busy          = (state_q != ST_IDLE);
   assign done          = done_c;
   assign beatCount     = beat_count_q;
   // The done cycle is still busy, so a start there counts as an overrun.
   assign overrunStrobe = start && busy;
   assign dbg_state     = state_q;

endmodule

// File: tb/tb_fofb_readout_sequencer.sv
`timescale 1ns/1ps
module tb_fofb_readout_sequencer;

   localparam int W = 9;
   localparam int N = 1 << W;

   // ---------------------------------------------------------------- clock/reset
   logic          sysClk = 1'b0;
   logic          sysReset;
   logic          start;
   logic [N-1:0]  bpmBitmap;
   logic [W-1:0]  readoutAddress;
   logic [31:0]   readoutX = '0;
   logic [31:0]   readoutY = '0;
   logic [31:0]   readoutS = '0;
   logic          hostReq;
   logic [W-1:0]  hostAddress;
   logic          hostValid;
   logic [95:0]   hostData;
   logic          busy;
   logic          done;
   logic [W:0]    beatCount;
   logic          overrunStrobe;
   logic [1:0]    dbg_state;

   fofb_readout_sequencer_if #(.FOFB_INDEX_WIDTH(W)) out_bus ();

   fofb_readout_sequencer #(.FOFB_INDEX_WIDTH(W)) dut (
      .sysClk         (sysClk),
      .sysReset       (sysReset),
      .start          (start),
      .bpmBitmap      (bpmBitmap),
      .readoutAddress (readoutAddress),
      .readoutX       (readoutX),
      .readoutY       (readoutY),
      .readoutS       (readoutS),
      .out_bus        (out_bus),
      .hostReq        (hostReq),
      .hostAddress    (hostAddress),
      .hostValid      (hostValid),
      .hostData       (hostData),
      .busy           (busy),
      .done           (done),
      .beatCount      (beatCount),
      .overrunStrobe  (overrunStrobe),
      .dbg_state      (dbg_state)
   );

   always #5 sysClk = ~sysClk;

   int cyc = 0;
   always @(posedge sysClk) cyc <= cyc + 1;

   // DPRAM contents and one-cycle read latency
   function automatic logic [31:0] mem_x(input int i);
      return 32'h1100_0000 + 32'(i);
   endfunction
   function automatic logic [31:0] mem_y(input int i);
      return 32'h2200_0000 + 32'(i) * 32'd257;
   endfunction
   function automatic logic [31:0] mem_s(input int i);
      return 32'h3300_0000 ^ (32'(i) << 8) ^ 32'(i);
   endfunction

   always @(posedge sysClk) begin
      readoutX <= mem_x(int'(readoutAddress));
      readoutY <= mem_y(int'(readoutAddress));
      readoutS <= mem_s(int'(readoutAddress));
   end

   // ---------------------------------------------------------------- scoreboard
   int n_cmp = 0;
   int n_err = 0;
   logic [105:0] exp_q[$];
   logic [95:0]  host_q[$];

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      n_cmp++;
      n_err++;
      $display("FAIL %s", name);
   endtask

   function automatic logic [105:0] beat_vec(input int i, input logic last);
      logic [W-1:0] iv;
      iv = W'(i);
      return {iv, last, mem_s(i), mem_y(i), mem_x(i)};
   endfunction

   task automatic push_beats(input logic [N-1:0] bm);
      int hi;
      hi = -1;
      for (int i = 0; i < N; i++) if (bm[i]) hi = i;
      for (int i = 0; i < N; i++) if (bm[i]) exp_q.push_back(beat_vec(i, i == hi));
   endtask

   // ---------------------------------------------------------------- monitor
   int beats_seen = 0;
   int done_cnt = 0;
   int ovr_cnt = 0;
   int last_xfer_cyc = 0;
   logic prev_stall = 1'b0;
   logic [105:0] prev_head = '0;

   always @(negedge sysClk) begin : monitor
      logic [105:0] head;
      head = {out_bus.outIndex, out_bus.outLast, out_bus.outS, out_bus.outY, out_bus.outX};
      if (sysReset) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) check("stall_hold", {out_bus.outValid, head}, {1'b1, prev_head});
         if (out_bus.outValid && out_bus.outReady) begin
            beats_seen++;
            last_xfer_cyc = cyc;
            if (exp_q.size() == 0) fail_now("beat_unexpected");
            else check("beat", head, exp_q.pop_front());
         end
         prev_stall = out_bus.outValid && !out_bus.outReady;
         prev_head  = head;
         if (hostValid) begin
            if (host_q.size() == 0) fail_now("host_unexpected");
            else check("host_data", hostData, host_q.pop_front());
         end
         if (done) done_cnt++;
         if (overrunStrobe) ovr_cnt++;
      end
   end

   // ---------------------------------------------------------------- drivers
   int ready_mode = 0;
   initial begin
      out_bus.outReady = 1'b1;
      forever begin
         @(posedge sysClk); #1;
         out_bus.outReady = (ready_mode == 0) ? 1'b1 : ((cyc % 4) == 0);
      end
   end

   int start_cyc = 0;
   int done_cyc = 0;
   int busy_cycles = 0;
   int valid_cycles = 0;
   int first_valid_cyc = -1;

   task automatic do_reset();
      @(posedge sysClk); #1;
      sysReset = 1'b1;
      repeat (2) @(posedge sysClk);
      #1 sysReset = 1'b0;
      exp_q.delete();
      host_q.delete();
   endtask

   task automatic pulse_start(input logic [N-1:0] bm);
      @(posedge sysClk); #1;
      bpmBitmap = bm;
      start     = 1'b1;
      start_cyc = cyc;
      @(posedge sysClk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input int budget, output logic ok);
      busy_cycles     = 0;
      valid_cycles    = 0;
      first_valid_cyc = -1;
      ok              = 1'b0;
      for (int k = 0; k < budget; k++) begin
         @(negedge sysClk);
         if (busy) busy_cycles++;
         if (out_bus.outValid) begin
            valid_cycles++;
            if (first_valid_cyc < 0) first_valid_cyc = cyc;
         end
         if (done) begin
            done_cyc = cyc;
            ok = 1'b1;
            break;
         end
      end
      if (!ok) fail_now("done_timeout");
   endtask

   task automatic host_read(input logic [W-1:0] a, input int exp_lat);
      int rc;
      logic got;
      @(posedge sysClk); #1;
      hostAddress = a;
      hostReq     = 1'b1;
      rc          = cyc;
      host_q.push_back({mem_s(int'(a)), mem_y(int'(a)), mem_x(int'(a))});
      got = 1'b0;
      for (int k = 0; k < 10; k++) begin
         @(negedge sysClk);
         if (hostValid) begin
            got = 1'b1;
            check("host_latency", cyc - rc, exp_lat);
            break;
         end
      end
      if (!got) fail_now("host_timeout");
      @(posedge sysClk); #1;
      hostReq = 1'b0;
   endtask

   // ---------------------------------------------------------------- stimulus
   logic [N-1:0] bm;
   logic ok;
   int d0, o0, b0;

   initial begin
      sysReset    = 1'b1;
      start       = 1'b0;
      bpmBitmap   = '0;
      hostReq     = 1'b0;
      hostAddress = '0;

      // Reset state
      repeat (2) @(posedge sysClk);
      #1;
      check("rst_outValid", out_bus.outValid, 0);
      check("rst_outIndex", out_bus.outIndex, 0);
      check("rst_outX", out_bus.outX, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_beatCount", beatCount, 0);
      check("rst_hostValid", hostValid, 0);
      check("rst_hostData", hostData, 0);
      check("rst_readoutAddress", readoutAddress, 0);
      check("rst_overrun", overrunStrobe, 0);
      check("rst_state", dbg_state, 0);
      #1 sysReset = 1'b0;

      // Sparse bitmap {3,7,511}
      do_reset();
      bm = '0; bm[3] = 1'b1; bm[7] = 1'b1; bm[511] = 1'b1;
      push_beats(bm);
      d0 = done_cnt;
      pulse_start(bm);
      wait_done(2000, ok);
      check("t1_done_after_last", done_cyc, last_xfer_cyc + 1);
      @(negedge sysClk);
      check("t1_beatCount", beatCount, 3);
      check("t1_busy_low", busy, 0);
      check("t1_queue_empty", exp_q.size(), 0);
      check("t1_done_pulses", done_cnt - d0, 1);

      // Empty bitmap
      do_reset();
      pulse_start('0);
      wait_done(20, ok);
      check("t2_done_latency", done_cyc - start_cyc, 2);
      check("t2_busy_cycles", busy_cycles, 2);
      check("t2_no_valid", valid_cycles, 0);
      @(negedge sysClk);
      check("t2_beatCount", beatCount, 0);

      // Full bitmap with a stalling sink
      do_reset();
      ready_mode = 1;
      bm = '1;
      push_beats(bm);
      pulse_start(bm);
      wait_done(5000, ok);
      @(negedge sysClk);
      check("t3_beatCount", beatCount, N);
      check("t3_queue_empty", exp_q.size(), 0);
      ready_mode = 0;

      // Full bitmap with host reads competing, then an idle host read
      do_reset();
      bm = '1;
      push_beats(bm);
      pulse_start(bm);
      fork
         begin
            repeat (10) @(posedge sysClk);
            host_read(9'd42, 2);
            host_read(9'd43, 2);
            host_read(9'd0, 2);
            host_read(9'd511, 2);
         end
         wait_done(3000, ok);
      join
      @(negedge sysClk);
      check("t4_beatCount", beatCount, N);
      check("t4_queue_empty", exp_q.size(), 0);
      host_read(9'd7, 1);
      check("t4_host_queue_empty", host_q.size(), 0);

      // Overrun: second start during a scan of {100}
      do_reset();
      bm = '0; bm[100] = 1'b1;
      push_beats(bm);
      o0 = ovr_cnt;
      pulse_start(bm);
      repeat (3) @(posedge sysClk);
      #1;
      bpmBitmap = '1;
      start     = 1'b1;
      @(posedge sysClk); #1;
      start = 1'b0;
      wait_done(1000, ok);
      @(negedge sysClk);
      check("t5_overrun_pulses", ovr_cnt - o0, 1);
      check("t5_beatCount", beatCount, 1);
      check("t5_queue_empty", exp_q.size(), 0);

      // Reset mid-scan after 5 beats, then a fresh scan
      bm = '1;
      push_beats(bm);
      d0 = done_cnt;
      b0 = beats_seen;
      pulse_start(bm);
      ok = 1'b0;
      for (int k = 0; k < 100; k++) begin
         @(negedge sysClk);
         if (beats_seen >= b0 + 5) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) fail_now("t6_five_beats_timeout");
      @(posedge sysClk); #3;
      sysReset = 1'b1;
      #1;
      check("t6_rst_outValid", out_bus.outValid, 0);
      check("t6_rst_busy", busy, 0);
      check("t6_rst_beatCount", beatCount, 0);
      check("t6_rst_readoutAddress", readoutAddress, 0);
      check("t6_rst_outS", out_bus.outS, 0);
      exp_q.delete();
      repeat (3) @(posedge sysClk);
      #1 sysReset = 1'b0;
      check("t6_no_done", done_cnt, d0);
      bm = '0; bm[0] = 1'b1; bm[1] = 1'b1; bm[2] = 1'b1;
      bm[255] = 1'b1; bm[256] = 1'b1; bm[510] = 1'b1;
      push_beats(bm);
      pulse_start(bm);
      wait_done(2000, ok);
      check("t6_first_beat_latency", first_valid_cyc - start_cyc, 2);
      @(negedge sysClk);
      check("t6_beatCount", beatCount, 6);
      check("t6_queue_empty", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
      $fatal(1, "watchdog");
   end

endmodule
